// File: rtl/dwt53_row_fwd.sv
// Forward 5/3 lifting DWT over one line, emitting interleaved L,H; DWT53_BYPASS_EN adds a per-line pass-through.
// Latency: L[n] one cycle after x[2n+2] (or the tlast sample); H[n] the cycle after L[n] is taken.
// Backpressure: results sit in a 3-entry queue; input is held off until the worst-case push for the state fits.
module dwt53_row_fwd #(
    parameter int DataWidth = 16,
    parameter int OutWidth  = DataWidth + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
`ifdef DWT53_BYPASS_EN
    input  logic                 bypass_i,
`endif
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tlast,
    input  logic [DataWidth-1:0] s_axis_tdata,
    output logic                 s_axis_tready,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic [OutWidth-1:0]  m_axis_tdata,
    input  logic                 m_axis_tready
);

    localparam int AW = OutWidth + 2;
    localparam logic signed [AW-1:0] RND = AW'(2);

    typedef enum logic [1:0] {FIRST, ODD, EVEN, FLUSH} state_t;
    typedef struct packed {
        logic                user;
        logic                last;
        logic [OutWidth-1:0] dat;
    } entry_t;

    state_t               state, state_n;
    entry_t               q [3];
    entry_t               q_n [3];
    entry_t               push [3];
    logic [1:0]           cnt, cnt_n, npush, c0;
    logic [DataWidth-1:0] x_even, x_odd;
    logic [OutWidth-1:0]  h_prev;
    logic                 first_pair, user_l, line_byp, byp_sel;
    logic                 at_first, take, pop;
    logic [2:0]           need, space;
    logic signed [AW-1:0] xin, xe, xo, h_a, h_b, h_n, hp, l_n, l_fin;

    function automatic logic signed [AW-1:0] sx_d(input logic [DataWidth-1:0] v);
        return {{(AW-DataWidth){v[DataWidth-1]}}, v};
    endfunction

    function automatic logic signed [AW-1:0] sx_o(input logic [OutWidth-1:0] v);
        return {{(AW-OutWidth){v[OutWidth-1]}}, v};
    endfunction

    assign at_first = (state == FIRST) || (state == FLUSH);
`ifdef DWT53_BYPASS_EN
    assign byp_sel = at_first ? bypass_i : line_byp;
`else
    assign byp_sel = 1'b0;
`endif

    assign m_axis_tvalid = (cnt != 2'd0);
    assign m_axis_tuser  = q[0].user;
    assign m_axis_tlast  = q[0].last;
    assign m_axis_tdata  = q[0].dat;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign take          = s_axis_tvalid && s_axis_tready;

    // In ODD the incoming sample is x[2n+1] and x[2n+2] is mirrored onto x[2n].
    assign xin   = sx_d(s_axis_tdata);
    assign xe    = sx_d(x_even);
    assign xo    = sx_d(x_odd);
    assign h_a   = (state == ODD) ? xin : xo;
    assign h_b   = (state == ODD) ? xe : xin;
    assign h_n   = h_a - ((xe + h_b) >>> 1);
    assign hp    = first_pair ? h_n : sx_o(h_prev);
    assign l_n   = xe + ((hp + h_n + RND) >>> 2);
    assign l_fin = xin + ((h_n + h_n + RND) >>> 2);

    always_comb begin
        need = 3'd1;
        if (!at_first && !line_byp)
            need = (state == EVEN) ? 3'd3 : 3'd2;
        space = 3'd3 - {1'b0, cnt} + {2'b0, pop};
        if (state == FLUSH)
            s_axis_tready = pop && q[0].last;
        else
            s_axis_tready = (space >= need);
    end

    always_comb begin
        state_n = state;
        npush   = 2'd0;
        for (int i = 0; i < 3; i++) push[i] = '0;
        if (take) begin
            case (state)
                FIRST, FLUSH: begin
                    if (byp_sel || s_axis_tlast) begin
                        push[0] = '{user: s_axis_tuser, last: s_axis_tlast, dat: xin[OutWidth-1:0]};
                        npush   = 2'd1;
                    end
                    state_n = s_axis_tlast ? FLUSH : ODD;
                end
                ODD: begin
                    if (line_byp) begin
                        push[0] = '{user: 1'b0, last: s_axis_tlast, dat: xin[OutWidth-1:0]};
                        npush   = 2'd1;
                        state_n = s_axis_tlast ? FLUSH : ODD;
                    end else if (s_axis_tlast) begin
                        push[0] = '{user: first_pair && user_l, last: 1'b0, dat: l_n[OutWidth-1:0]};
                        push[1] = '{user: 1'b0, last: 1'b1, dat: h_n[OutWidth-1:0]};
                        npush   = 2'd2;
                        state_n = FLUSH;
                    end else begin
                        state_n = EVEN;
                    end
                end
                EVEN: begin
                    push[0] = '{user: first_pair && user_l, last: 1'b0, dat: l_n[OutWidth-1:0]};
                    push[1] = '{user: 1'b0, last: 1'b0, dat: h_n[OutWidth-1:0]};
                    if (s_axis_tlast) begin
                        push[2] = '{user: 1'b0, last: 1'b1, dat: l_fin[OutWidth-1:0]};
                        npush   = 2'd3;
                        state_n = FLUSH;
                    end else begin
                        npush   = 2'd2;
                        state_n = ODD;
                    end
                end
                default: ;
            endcase
        end else if (state == FLUSH && pop && q[0].last) begin
            state_n = FIRST;
        end
    end

    // Pop shifts the queue down; pushes append behind whatever remains.
    always_comb begin
        logic [1:0] wi;
        c0 = cnt - {1'b0, pop};
        q_n[0] = pop ? q[1] : q[0];
        q_n[1] = pop ? q[2] : q[1];
        q_n[2] = q[2];
        for (int j = 0; j < 3; j++) begin
            wi = c0 + 2'(j);
            if (j < int'(npush) && wi != 2'd3)
                q_n[wi] = push[j];
        end
        cnt_n = c0 + npush;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= FIRST;
            cnt        <= 2'd0;
            for (int i = 0; i < 3; i++) q[i] <= '0;
            x_even     <= '0;
            x_odd      <= '0;
            h_prev     <= '0;
            first_pair <= 1'b1;
            user_l     <= 1'b0;
            line_byp   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q     <= q_n;
            if (take) begin
                if (at_first) begin
                    x_even     <= s_axis_tdata;
                    user_l     <= s_axis_tuser;
                    first_pair <= 1'b1;
                    line_byp   <= byp_sel;
                end else if (state == ODD) begin
                    x_odd <= s_axis_tdata;
                end else if (state == EVEN) begin
                    x_even     <= s_axis_tdata;
                    h_prev     <= h_n[OutWidth-1:0];
                    first_pair <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dwt53_row_fwd.sv
// Bench for dwt53_row_fwd: hand-computed line vectors, throughput, random backpressure, mid-line reset.
module tb_dwt53_row_fwd;
    localparam int DW = 16;
    localparam int OW = 17;

    typedef int iq_t[$];
    typedef struct {
        int n;
        int x[6];
        int e[6];
        bit u;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0, s_tready;
    logic [DW-1:0] s_tdata = '0;
    logic          m_tvalid, m_tuser, m_tlast;
    logic [OW-1:0] m_tdata;
    logic          m_tready = 1'b1;
    logic          bypass = 1'b0;
    bit            rand_rdy = 1'b0;

    int checks = 0, errors = 0;
    int got_d[$];
    bit got_l[$];
    bit got_u[$];
    int rd = 0;
    int stall_obs = 0, stall_viol = 0;
    logic          p_stall = 1'b0, p_last, p_user;
    logic [OW-1:0] p_dat;

    dwt53_row_fwd dut (
        .clk_i         (clk),
        .rst_i         (rst),
`ifdef DWT53_BYPASS_EN
        .bypass_i      (bypass),
`endif
        .s_axis_tvalid (s_tvalid),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tdata  (s_tdata),
        .s_axis_tready (s_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tready (m_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                stall_obs++;
                if (!(m_tvalid && m_tdata == p_dat && m_tlast == p_last && m_tuser == p_user))
                    stall_viol++;
            end
            if (m_tvalid && m_tready) begin
                got_d.push_back(int'($signed(m_tdata)));
                got_l.push_back(m_tlast);
                got_u.push_back(m_tuser);
            end
            p_stall = m_tvalid && !m_tready;
            p_dat   = m_tdata;
            p_last  = m_tlast;
            p_user  = m_tuser;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference built straight from the lifting equations with mirrored edges.
    function automatic iq_t model(input iq_t xs);
        iq_t e, h;
        int  n;
        n = xs.size();
        if (n == 1) begin
            e.push_back(xs[0]);
            return e;
        end
        for (int k = 0; k < n / 2; k++) begin
            int xr;
            xr = (2 * k + 2 < n) ? xs[2 * k + 2] : xs[n - 2];
            h.push_back(xs[2 * k + 1] - ((xs[2 * k] + xr) >>> 1));
        end
        for (int k = 0; k < (n + 1) / 2; k++) begin
            int hl, hr;
            hl = (k == 0) ? h[0] : h[k - 1];
            hr = (k < h.size()) ? h[k] : h[h.size() - 1];
            e.push_back(xs[2 * k] + ((hl + hr + 2) >>> 2));
            if (k < h.size()) e.push_back(h[k]);
        end
        return e;
    endfunction

    // Called and returns at posedge+1.
    task automatic send_sample(input int d, input bit u, input bit l, input int gap, output int st);
        int g;
        g = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
        s_tvalid = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b1;
        s_tdata  = d[DW-1:0];
        s_tuser  = u;
        s_tlast  = l;
        st = 0;
        @(negedge clk);
        while (!s_tready && st < 200) begin
            st++;
            @(negedge clk);
        end
        if (st >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: s_axis_tready low for %0d cycles, required high within 200", st);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_line(input iq_t xs, input bit u, input int gap, output int s0, output int srest);
        int st;
        srest = 0;
        s0 = 0;
        for (int i = 0; i < xs.size(); i++) begin
            send_sample(xs[i], u && (i == 0), i == xs.size() - 1, gap, st);
            if (i == 0) s0 = st;
            else srest += st;
        end
    endtask

    task automatic check_line(input string name, input iq_t ex, input bit u);
        int t, n, avail;
        n = ex.size();
        t = 0;
        while (got_d.size() < rd + n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        avail = got_d.size() - rd;
        chk({name, ".count"}, (avail > n) ? n : avail, n);
        for (int k = 0; k < n; k++) begin
            if (k < avail) begin
                chk($sformatf("%s[%0d].data", name, k), got_d[rd + k], ex[k]);
                chk($sformatf("%s[%0d].tlast", name, k), int'(got_l[rd + k]), int'(k == n - 1));
                chk($sformatf("%s[%0d].tuser", name, k), int'(got_u[rd + k]), int'(u && k == 0));
            end
        end
        rd += (avail > n) ? n : avail;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[6];
        iq_t  xs, ex;
        int   s0, sr;
        int   g0[3];
        int   gr[3];
        iq_t  lines[3];

        tbl[0] = '{n: 4, x: '{10, 20, 30, 40, 0, 0},           e: '{10, 0, 33, 10, 0, 0},             u: 1'b1};
        tbl[1] = '{n: 3, x: '{4, 8, 2, 0, 0, 0},               e: '{7, 5, 5, 0, 0, 0},                u: 1'b0};
        tbl[2] = '{n: 1, x: '{5, 0, 0, 0, 0, 0},               e: '{5, 0, 0, 0, 0, 0},                u: 1'b1};
        tbl[3] = '{n: 2, x: '{-3, 0, 0, 0, 0, 0},              e: '{-1, 3, 0, 0, 0, 0},               u: 1'b0};
        tbl[4] = '{n: 6, x: '{100, -50, 7, -8, 9, 1000},       e: '{49, -103, -23, -16, 253, 991},    u: 1'b0};
        tbl[5] = '{n: 3, x: '{-32768, 32767, -32768, 0, 0, 0}, e: '{0, 65535, 0, 0, 0, 0},            u: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset.tvalid", int'(m_tvalid), 0);
        chk("reset.tdata", int'(m_tdata), 0);
        chk("reset.tuser", int'(m_tuser), 0);
        chk("reset.tlast", int'(m_tlast), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            xs = {};
            ex = {};
            for (int i = 0; i < tbl[v].n; i++) begin
                xs.push_back(tbl[v].x[i]);
                ex.push_back(tbl[v].e[i]);
            end
            send_line(xs, tbl[v].u, 0, s0, sr);
            check_line($sformatf("vec%0d", v), ex, tbl[v].u);
        end

        // Back-to-back lines with the sink always ready.
        for (int l = 0; l < 3; l++) begin
            lines[l] = {};
            for (int i = 0; i < 16; i++) lines[l].push_back(i * 37 - 200 + l * 5);
        end
        for (int l = 0; l < 3; l++) send_line(lines[l], 1'b0, 0, g0[l], gr[l]);
        for (int l = 0; l < 3; l++) begin
            check_line($sformatf("thru%0d", l), model(lines[l]), 1'b0);
            chk($sformatf("thru%0d.in_line_stalls", l), gr[l], 0);
            if (l > 0) begin
                checks++;
                if (g0[l] > 2) begin
                    errors++;
                    $display("FAIL thru%0d.line_gap: got %0d idle cycles, expected at most 2", l, g0[l]);
                end
            end
        end

        rand_rdy = 1'b1;
        for (int l = 0; l < 3; l++) begin
            xs = {};
            for (int i = 0; i < 64; i++) xs.push_back(int'($urandom_range(0, 65535)) - 32768);
            send_line(xs, l == 0, 2, s0, sr);
            check_line($sformatf("rand%0d", l), model(xs), l == 0);
        end
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Abandon a line after three samples.
        send_sample(1, 1'b1, 1'b0, 0, s0);
        send_sample(2, 1'b0, 1'b0, 0, s0);
        send_sample(3, 1'b0, 1'b0, 0, s0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset.tvalid", int'(m_tvalid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd = got_d.size();
        @(posedge clk);
        #1;
        xs = {10, 20, 30, 40};
        ex = {10, 0, 33, 10};
        send_line(xs, 1'b1, 0, s0, sr);
        check_line("post_reset", ex, 1'b1);

`ifdef DWT53_BYPASS_EN
        bypass = 1'b1;
        xs = {-3, 0};
        ex = {-3, 0};
        send_line(xs, 1'b1, 0, s0, sr);
        bypass = 1'b0;
        check_line("bypass", ex, 1'b1);
`endif

        repeat (10) @(negedge clk);
        chk("extra_outputs", got_d.size(), rd);
        chk("stall_hold_violations", stall_viol, 0);
        chk("stalls_seen", int'(stall_obs > 0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dwt53_row_fwd.md
Name: dwt53_row_fwd

Overview:
- Forward horizontal 5/3 reversible lifting DWT (JPEG2000 integer filter) over one image line at a time.
- Input is an AXI-stream of signed samples: tuser = start of frame, tlast = end of line.
- Output is interleaved subband coefficients L0,H0,L1,H1,… with symmetric boundary extension.
- Sits directly upstream of the in-line reorder stage, which splits the interleaved stream into L-then-H line order.

Parameters:
- DataWidth, 16, signed input sample width.
- OutWidth, DataWidth+1, signed output coefficient width; this width fits the worst-case H growth.

Ports:
- clk_i  input  1  clock, all logic on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- s_axis_tvalid  input  1  input sample valid.
- s_axis_tuser  input  1  start of frame; meaningful on the first sample of a line only.
- s_axis_tlast  input  1  last sample of line.
- s_axis_tdata  input  DataWidth  signed sample x[i].
- s_axis_tready  output  1  input accept.
- m_axis_tvalid  output  1  coefficient valid.
- m_axis_tuser  output  1  start of frame, asserted on L0 of the frame's first line.
- m_axis_tlast  output  1  last coefficient of line.
- m_axis_tdata  output  OutWidth  signed coefficient.
- m_axis_tready  input  1  downstream accept.

Behaviour:
- Reset: all outputs 0; state FIRST; all sample and H history registers cleared. Reset mid-line discards partial line state; the next accepted sample is treated as x[0].
- Handshake: transfer occurs when valid&&ready. m_axis_tvalid, once high, holds with stable data, tuser and tlast until accepted. s_axis_tready must not depend combinationally on s_axis_tvalid.
- Math, line length N≥1, all arithmetic done in OutWidth+2 bits, floor = arithmetic shift right:
  - H[n] = x[2n+1] − floor((x[2n]+x[2n+2])/2)
  - L[n] = x[2n] + floor((H[n−1]+H[n]+2)/4)
- Boundary extension:
  - x[N] = x[N−2] for even N.
  - H[−1] = H[0].
  - For odd N, final L uses H[n] = H[n−1].
  - N = 1: L0 = x[0].
- Output order: L[n] then H[n] for each pair. For odd N the line ends with L[(N−1)/2] alone. m_axis_tlast is asserted on the final output of the line. Output count is exactly N.
- States:
  - FIRST: expect x[0].
  - ODD: expect x[2n+1].
  - EVEN: expect x[2n+2]. Accepting it computes H[n], L[n] and queues the pair.
  - FLUSH: emit the final pair, or the single L, after tlast.
  - Return to FIRST when the tlast output is accepted.
- Transitions on tlast:
  - tlast on an odd index → compute H with extension and queue the last pair.
  - tlast on an even index → compute the final L (N=1 passes x[0] through).
- Latency: L[n] is presented 1 cycle after acceptance of x[2n+2], or 1 cycle after the tlast sample for the final pair. H[n] is presented in the cycle after L[n] is accepted.
- Throughput: with m_axis_tready held high, input is accepted every cycle within a line. A bubble of at most 2 cycles is allowed between lines. No samples are lost or duplicated under arbitrary backpressure.
- tuser: latched from x[0]'s tuser and emitted on L0. tuser on a non-first sample is ignored.

Optional Feature:
- Macro DWT53_BYPASS_EN adds port bypass_i (input, 1 bit).
- bypass_i is sampled when x[0] is accepted and applies to the whole line.
- Bypass high: samples are passed through sign-extended to OutWidth, in order, with the same tuser/tlast placement and 1-cycle latency.
- Macro undefined: no port; the filter is always active.

Test Plan:
- Line [10,20,30,40], tuser on x0, tready=1 → outputs 10,0,33,10; tuser on first output; tlast on the 4th only.
- Line [4,8,2] (odd N) → outputs 7,5,5; tlast on the 3rd.
- Line [5] (N=1) → single output 5, tlast=1; line [-3,0] → outputs −1,3 (negative floor check).
- Random 64-sample lines with random m_axis_tready/s_axis_tvalid toggling → output matches the software model bit-exactly; no loss or duplication; data stable while stalled.
- Reset asserted after 3 samples of an 8-sample line, then a clean line [10,20,30,40] → tvalid 0 during reset; post-reset outputs 10,0,33,10.
- Continuous 16-sample lines with tready=1 → s_axis_tready high every cycle within a line; ≤2 idle cycles between lines. With DWT53_BYPASS_EN and bypass_i=1, [−3,0] → outputs −3,0.
